// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even
// parity bit, and a stop interval of SB_TICK oversampling ticks. Bit timing
// is driven by a 16x s_tick enable from an external baud-rate generator.
module uart_tx #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int PARITY_EN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  // Tick counter must hold SB_TICK-1 during the stop interval.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          p_q, p_d;
  logic          tx_q, tx_d;
  logic          done_c;

  // State, counters, shift register and line register, all on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is derived from the next state so the line
  // changes on exactly the edge where the state changes.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    done_c  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          p_d     = ^din[DBIT-1:0];
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PARITY:  tx_d = p_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  // A reset in the final stop cycle aborts the frame, so no completion pulse.
  assign tx_done_tick = done_c & ~rst;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances with different framing parameters share
// one stimulus stream; a tick-count model of each frame predicts tx, tx_busy
// and tx_done_tick every clock.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] tx_v, busy_v, done_v;

  int checks;
  int errors;

  // Framing of each instance: data bits, parity enable, stop ticks.
  int cfg_d  [4] = '{8, 8, 8, 7};
  int cfg_p  [4] = '{0, 1, 0, 1};
  int cfg_sb [4] = '{16, 16, 32, 24};

  // Reference model: frame in flight, ticks consumed, latched byte.
  logic       m_busy   [4];
  int         m_k      [4];
  logic [7:0] m_data   [4];
  int         m_frames [4];

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_tx #(.DBIT(7), .SB_TICK(24), .PARITY_EN(1)) u3 (
    .clk(clk), .rst(rst), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int total(input int i);
    return 16 * (1 + cfg_d[i] + cfg_p[i]) + cfg_sb[i];
  endfunction

  // Line level: start bit, data bits LSB first, even parity, then high.
  function automatic logic exp_tx(input int i);
    int idx;
    logic [7:0] mask;
    if (!m_busy[i]) return 1'b1;
    idx  = m_k[i] / 16;
    mask = 8'((32'd1 << cfg_d[i]) - 1);
    if (idx == 0) return 1'b0;
    if (idx <= cfg_d[i]) return m_data[i][idx-1];
    if (cfg_p[i] != 0 && idx == cfg_d[i] + 1) return ^(m_data[i] & mask);
    return 1'b1;
  endfunction

  // One clock: apply inputs, check all instances mid-cycle, advance model.
  task automatic cycle(input logic r, input logic st, input logic [7:0] d,
                       input logic tk);
    logic et, eb, ed;
    rst = r; tx_start = st; din = d; s_tick = tk;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      et = exp_tx(i);
      eb = m_busy[i];
      ed = m_busy[i] && tk && !r && (m_k[i] == total(i) - 1);
      checks++;
      assert (tx_v[i] === et) else begin
        errors++;
        $error("FAIL tx dut%0d t=%0t observed=%b expected=%b", i, $time, tx_v[i], et);
      end
      checks++;
      assert (busy_v[i] === eb) else begin
        errors++;
        $error("FAIL tx_busy dut%0d t=%0t observed=%b expected=%b", i, $time, busy_v[i], eb);
      end
      checks++;
      assert (done_v[i] === ed) else begin
        errors++;
        $error("FAIL tx_done_tick dut%0d t=%0t observed=%b expected=%b", i, $time, done_v[i], ed);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_busy[i] = 1'b0;
        m_k[i]    = 0;
      end else if (!m_busy[i]) begin
        if (st) begin
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
          m_data[i] = d;
        end
      end else if (tk) begin
        if (m_k[i] == total(i) - 1) begin
          m_busy[i] = 1'b0;
          m_frames[i]++;
        end else begin
          m_k[i]++;
        end
      end
    end
    #1;
  endtask

  // Start a frame with d0 and run until every instance is idle again.
  // hold: keep tx_start high with d1 until each instance finished 2 frames.
  // mode 0: s_tick every 4th clk, mode 1: random s_tick.
  // gap_at / rst_at: tick count at which to stall ticks for 100 clk / reset.
  task automatic run(input logic [7:0] d0, input logic [7:0] d1, input bit hold,
                     input int mode, input int gap_at, input int rst_at);
    int t, c, ph;
    logic tk, st, r;
    logic [7:0] d;
    bit gap_done, rst_done, all_busy, any_busy, need;
    t = 0; ph = 0; gap_done = 0; rst_done = 0;
    for (int i = 0; i < 4; i++) m_frames[i] = 0;
    cycle(1'b0, 1'b1, d0, 1'b0);
    c = 1;
    forever begin
      any_busy = 0; all_busy = 1; need = 0;
      for (int i = 0; i < 4; i++) begin
        any_busy = any_busy | m_busy[i];
        all_busy = all_busy & m_busy[i];
        if (m_frames[i] < 2) need = 1;
      end
      if (hold && need) begin
        st = 1'b1; d = d1;
      end else begin
        st = all_busy && ($urandom_range(0, 7) == 0);
        d  = 8'($urandom);
      end
      if (!st && !any_busy) break;
      if (mode == 0) begin
        tk = (ph == 3); ph = (ph + 1) % 4;
      end else begin
        tk = ($urandom_range(0, 2) == 0);
      end
      r = 1'b0;
      if (rst_at >= 0 && !rst_done && t == rst_at) begin
        r = 1'b1; rst_done = 1; st = 1'b1; tk = 1'b1;
      end
      if (gap_at >= 0 && !gap_done && t == gap_at) begin
        gap_done = 1;
        repeat (100) cycle(1'b0, 1'b0, 8'($urandom), 1'b0);
      end
      cycle(r, st, d, tk);
      if (tk) t++;
      c++;
      if (c > 20000) begin
        checks++;
        errors++;
        $error("FAIL timeout observed=%0d cycles expected=idle", c);
        break;
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; tx_start = 1'b0; din = 8'h00; s_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0; m_k[i] = 0; m_data[i] = 8'h00; m_frames[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with start and tick asserted alongside reset.
    cycle(1'b1, 1'b1, 8'hFF, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    run(8'h55, 8'h00, 0, 0, -1, -1);
    run(8'h07, 8'h00, 0, 0, -1, -1);
    run(8'hA3, 8'h3C, 1, 0, -1, -1);
    run(8'h00, 8'h00, 0, 1, -1, -1);
    run(8'h5A, 8'h00, 0, 0, 5, -1);
    run(8'hC4, 8'h00, 0, 0, -1, 72);
    run(8'hFF, 8'h00, 0, 0, -1, -1);
    repeat (4) run(8'($urandom), 8'h00, 0, 1, -1, -1);
    run(8'($urandom), 8'($urandom), 1, 1, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DBIT, default 8: number of data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick periods (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit between the data bits and the stop bit.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 s_tick  input  1  16x-oversampling enable, one clk wide, from the baud-rate mod-m counter.
REQ-007 tx_start  input  1  request to send din; sampled only in IDLE.
REQ-008 din  input  8  data byte; bits [DBIT-1:0] transmitted LSB first.
REQ-009 tx  output  1  serial line; idle high.
REQ-010 tx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 tx_done_tick  output  1  one-clk pulse marking frame completion.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; internal tick counter s (4 bits, or wide enough for SB_TICK-1), bit counter n (3 bits), shift register b (8 bits), parity register p.
REQ-013 IDLE: tx=1; tx_start=1 -> b<=din, s<=0, p<=^din[DBIT-1:0], next state START; s_tick is ignored.
REQ-014 START: tx=0; on s_tick with s==15 -> s<=0, n<=0, DATA; on s_tick otherwise -> s<=s+1.
REQ-015 DATA: tx=b[0]; on s_tick with s==15 -> s<=0, b<=b>>1; if n==DBIT-1, next state is PARITY when PARITY_EN=1, else STOP; otherwise n<=n+1.
REQ-016 PARITY (PARITY_EN=1 only): tx=p (even parity: total ones in data+parity is even); on s_tick with s==15 -> s<=0, STOP.
REQ-017 STOP: tx=1; on s_tick with s==SB_TICK-1 -> IDLE and tx_done_tick=1 for exactly that clk; on s_tick otherwise -> s<=s+1.
REQ-018 Counters advance only on clocks where s_tick=1; clocks without s_tick hold all state.
REQ-019 tx is driven from a register updated on the same edge as the state register, so it is glitch-free and changes on the edge on which the state changes.
REQ-020 tx_start and din are ignored outside IDLE; din may change freely after the accepting clk.
REQ-021 tx_start asserted in the tx_done_tick cycle is ignored; a new frame is accepted from the following clk in IDLE, so back-to-back frames are separated by at most one clk of idle line.
REQ-022 Frame length is exactly 16*(1+DBIT+PARITY_EN)+SB_TICK s_tick periods from the accepting clk to tx_done_tick.
REQ-023 tx_busy rises on the clk after tx_start is accepted and falls on the clk after tx_done_tick.

Reset
REQ-024 rst=1 on a rising clk edge forces state=IDLE, s=0, n=0, b=0, p=0, tx=1, tx_busy=0, tx_done_tick=0, regardless of the current state.
REQ-025 Reset mid-frame aborts the frame; tx returns high on the same edge and no tx_done_tick is produced for the aborted frame.
REQ-026 rst takes priority over tx_start and s_tick in the same cycle.

Verification
REQ-027 Defaults, s_tick every 4th clk, din=0x55 with tx_start for 1 clk -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 ticks (64 clk); tx_done_tick once, 160 ticks after start.
REQ-028 PARITY_EN=1, din=0x07 -> data bits 1,1,1,0,0,0,0,0 then parity bit 1, then stop; tx_done_tick after 176 ticks.
REQ-029 tx_start held high continuously, din=0xA3 then 0x3C -> two complete frames; the second start bit begins no more than 1 clk after the first tx_done_tick; tx_start pulses during a frame do not alter that frame.
REQ-030 rst asserted during DATA bit 3 -> tx=1, tx_busy=0 on the next edge; no tx_done_tick; a subsequent din=0xFF frame transmits correctly.
REQ-031 SB_TICK=32, din=0x00 -> stop level high for 32 ticks; tx_done_tick after 176 ticks.
REQ-032 s_tick held low for 100 clk mid-START -> tx stays 0 and no counter advances; the frame resumes when ticks resume.
